contador_updown_param: RTL and testbench
========================================

CONTADOR_UPDOWN_PARAM -- requirements
Module: contador_updown_param

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, 2..32.
REQ-002 Parameter RESET_VAL, default 106: value loaded on reset.
REQ-003 Parameter MIN_VAL, default 0: lower count bound.
REQ-004 Parameter MAX_VAL, default 255: upper count bound.
REQ-005 Parameter STEP, default 1: increment/decrement magnitude.
REQ-006 Parameter SATURATE, default 0: 0 = wrap within [MIN_VAL, MAX_VAL], 1 = clamp at bounds.
REQ-007 Legal parameters SHALL satisfy MIN_VAL <= RESET_VAL <= MAX_VAL <= 2^WIDTH-1 and 1 <= STEP <= MAX_VAL-MIN_VAL+1; illegal sets SHALL be flagged at elaboration.
REQ-008 clk  input  1  sole clock, all state updates on rising edge.
REQ-009 rst  input  1  synchronous reset, active-high.
REQ-010 en  input  1  count enable; gates acrescer/decrecer only.
REQ-011 acrescer  input  1  count up request.
REQ-012 decrecer  input  1  count down request.
REQ-013 carregar  input  1  synchronous load request.
REQ-014 valor_carga  input  WIDTH  load value.
REQ-015 limpar  input  1  clears sticky overflow flag.
REQ-016 saida  output  WIDTH  registered count value.
REQ-017 em_max  output  1  high while saida == MAX_VAL (decoded from register).
REQ-018 em_min  output  1  high while saida == MIN_VAL (decoded from register).
REQ-019 estouro  output  1  registered one-cycle pulse on bound crossing.
REQ-020 estouro_fixo  output  1  registered sticky overflow flag.

Function
REQ-021 Priority per edge SHALL be: rst > carregar > counting (en with acrescer/decrecer) > hold.
REQ-022 carregar=1: saida <= valor_carga clamped into [MIN_VAL, MAX_VAL], regardless of en/acrescer/decrecer; estouro <= 0.
REQ-023 en=1, {acrescer,decrecer}=10: count up by STEP; =01: count down by STEP; =11 or 00: hold; en=0: hold.
REQ-024 Arithmetic SHALL use WIDTH+1 bits internally; no intermediate truncation.
REQ-025 Up crossing: saida+STEP > MAX_VAL is a crossing; down crossing: saida < MIN_VAL+STEP is a crossing.
REQ-026 SATURATE=0 up crossing: saida <= MIN_VAL + (saida + STEP - MAX_VAL - 1); down crossing: saida <= MAX_VAL - (MIN_VAL + STEP - saida - 1).
REQ-027 SATURATE=1: up crossing -> saida <= MAX_VAL; down crossing -> saida <= MIN_VAL; attempting to count past a bound already held also counts as a crossing.
REQ-028 estouro SHALL be 1 in the cycle after a crossing edge, 0 otherwise; latency one clock.
REQ-029 estouro_fixo SHALL set on any crossing and hold until limpar=1; if crossing and limpar coincide, set wins.
REQ-030 Hold cases (en=0, 00, 11) SHALL leave saida unchanged and drive estouro 0.

Reset
REQ-031 rst=1 at a rising edge: saida <= RESET_VAL, estouro <= 0, estouro_fixo <= 0, overriding every other input including carregar.
REQ-032 Reset mid-count SHALL discard any pending operation; counting resumes on the first edge with rst=0.
REQ-033 em_max/em_min SHALL reflect RESET_VAL immediately after reset (default: both 0).

Verification
REQ-034 Defaults, rst then en=1 acrescer=1 for 3 edges -> saida 106,107,108,109; estouro 0.
REQ-035 Defaults, load 255 then one up edge -> saida 0, estouro 1 for one cycle, estouro_fixo 1 until limpar pulse -> 0.
REQ-036 MIN=10 MAX=20 STEP=3 SATURATE=0, load 19, up -> 11; down from 11 -> 19; both crossings pulse estouro.
REQ-037 MIN=10 MAX=20 STEP=3 SATURATE=1, load 19, up twice -> 20, 20, estouro 1 both cycles; load 5 -> saida 10 (clamped), em_min 1.
REQ-038 Defaults, acrescer=decrecer=1 or en=0 for 4 edges -> saida constant; carregar with acrescer -> load wins; rst with carregar -> 106.

Source files
------------

// File: rtl/contador_updown_param.sv
// Parameterised up/down counter with a configurable [MIN_VAL, MAX_VAL] range and step.
// On a bound crossing it either wraps or clamps, and it reports the crossing as a pulse and as a sticky flag.
module contador_updown_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 106,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = 255,
    parameter int unsigned STEP      = 1,
    parameter int unsigned SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             acrescer,
    input  logic             decrecer,
    input  logic             carregar,
    input  logic [WIDTH-1:0] valor_carga,
    input  logic             limpar,
    output logic [WIDTH-1:0] saida,
    output logic             em_max,
    output logic             em_min,
    output logic             estouro,
    output logic             estouro_fixo
);

    localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;
    localparam bit LEGAL = (WIDTH >= 2) && (WIDTH <= 32)
                        && (MIN_VAL <= RESET_VAL) && (RESET_VAL <= MAX_VAL)
                        && (64'(MAX_VAL) <= LIMIT)
                        && (STEP >= 1)
                        && (64'(STEP) <= 64'(MAX_VAL) - 64'(MIN_VAL) + 64'd1);

    if (!LEGAL) begin : g_illegal_params
        $error("contador_updown_param: illegal parameter set");
    end

    // One extra bit keeps saida+STEP and MIN_VAL+STEP exact before any wrap/clamp decision.
    localparam logic [WIDTH:0] MIN_X  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } op_e;

    op_e              op;
    logic [WIDTH:0]   cur_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   down_floor;
    logic             cross_up;
    logic             cross_dn;
    logic             crossing;
    logic [WIDTH-1:0] next_val;

    assign cur_x      = {1'b0, saida};
    assign load_x     = {1'b0, valor_carga};
    assign sum_up     = cur_x + STEP_X;
    assign down_floor = MIN_X + STEP_X;
    assign cross_up   = sum_up > MAX_X;
    assign cross_dn   = cur_x < down_floor;

    // Load beats counting; simultaneous up and down requests cancel to a hold.
    always_comb begin
        op = OP_HOLD;
        if (carregar)
            op = OP_LOAD;
        else if (en && acrescer && !decrecer)
            op = OP_UP;
        else if (en && !acrescer && decrecer)
            op = OP_DOWN;
    end

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_val = saida;
        crossing = 1'b0;
        case (op)
            OP_LOAD: begin
                if (load_x < MIN_X)
                    next_val = WIDTH'(MIN_X);
                else if (load_x > MAX_X)
                    next_val = WIDTH'(MAX_X);
                else
                    next_val = valor_carga;
            end
            OP_UP: begin
                if (cross_up) begin
                    crossing = 1'b1;
                    if (SATURATE != 0)
                        next_val = WIDTH'(MAX_X);
                    else
                        next_val = WIDTH'(MIN_X + (sum_up - MAX_X - ONE_X));
                end else begin
                    next_val = WIDTH'(sum_up);
                end
            end
            OP_DOWN: begin
                if (cross_dn) begin
                    crossing = 1'b1;
                    if (SATURATE != 0)
                        next_val = WIDTH'(MIN_X);
                    else
                        next_val = WIDTH'(MAX_X - (down_floor - cur_x - ONE_X));
                end else begin
                    next_val = WIDTH'(cur_x - STEP_X);
                end
            end
            default: begin
                next_val = saida;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            saida        <= RESET_W;
            estouro      <= 1'b0;
            estouro_fixo <= 1'b0;
        end else begin
            saida   <= next_val;
            estouro <= crossing;
            // A crossing in the same cycle as limpar keeps the flag set.
            if (crossing)
                estouro_fixo <= 1'b1;
            else if (limpar)
                estouro_fixo <= 1'b0;
        end
    end

    assign em_max = (cur_x == MAX_X);
    assign em_min = (cur_x == MIN_X);

endmodule

// File: tb/tb_contador_updown_param.sv
// Directed bench for contador_updown_param: default range, a wrapping 10..20 step-3 counter
// and a saturating 10..20 step-3 counter, all driven from shared stimulus.
module tb_contador_updown_param;

    logic       clk = 1'b0;
    logic       rst, en, acrescer, decrecer, carregar, limpar;
    logic [7:0] valor_carga;

    logic [7:0] d0_saida, d1_saida, d2_saida;
    logic       d0_max, d0_min, d0_est, d0_fixo;
    logic       d1_max, d1_min, d1_est, d1_fixo;
    logic       d2_max, d2_min, d2_est, d2_fixo;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    contador_updown_param u_def (
        .clk(clk), .rst(rst), .en(en), .acrescer(acrescer), .decrecer(decrecer),
        .carregar(carregar), .valor_carga(valor_carga), .limpar(limpar),
        .saida(d0_saida), .em_max(d0_max), .em_min(d0_min),
        .estouro(d0_est), .estouro_fixo(d0_fixo)
    );

    contador_updown_param #(.RESET_VAL(15), .MIN_VAL(10), .MAX_VAL(20), .STEP(3), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .acrescer(acrescer), .decrecer(decrecer),
        .carregar(carregar), .valor_carga(valor_carga), .limpar(limpar),
        .saida(d1_saida), .em_max(d1_max), .em_min(d1_min),
        .estouro(d1_est), .estouro_fixo(d1_fixo)
    );

    contador_updown_param #(.RESET_VAL(15), .MIN_VAL(10), .MAX_VAL(20), .STEP(3), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .acrescer(acrescer), .decrecer(decrecer),
        .carregar(carregar), .valor_carga(valor_carga), .limpar(limpar),
        .saida(d2_saida), .em_max(d2_max), .em_min(d2_min),
        .estouro(d2_est), .estouro_fixo(d2_fixo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled at the same point after the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic up, input logic dn,
                         input logic ld, input logic [7:0] v, input logic clr);
        rst = r; en = e; acrescer = up; decrecer = dn; carregar = ld; valor_carga = v; limpar = clr;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 8'd0, 0);
        tick();
        check("rst_saida", d0_saida, 106);
        check("rst_est", d0_est, 0);
        check("rst_fixo", d0_fixo, 0);
        check("rst_em_max", d0_max, 0);
        check("rst_em_min", d0_min, 0);
        check("rst_wrap_saida", d1_saida, 15);

        // Count up three times from the reset value
        drive(0, 1, 1, 0, 0, 8'd0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("up_%0d", i), d0_saida, 106 + i);
            check($sformatf("up_est_%0d", i), d0_est, 0);
        end

        // Default range wrap at 255 -> 0, sticky flag and clear
        drive(0, 0, 0, 0, 1, 8'd255, 0);
        tick();
        check("ld255", d0_saida, 255);
        check("ld255_em_max", d0_max, 1);
        check("ld255_est", d0_est, 0);
        drive(0, 1, 1, 0, 0, 8'd0, 0);
        tick();
        check("wrap_saida", d0_saida, 0);
        check("wrap_est", d0_est, 1);
        check("wrap_fixo", d0_fixo, 1);
        check("wrap_em_min", d0_min, 1);
        drive(0, 0, 0, 0, 0, 8'd0, 0);
        tick();
        check("post_wrap_est", d0_est, 0);
        check("post_wrap_fixo", d0_fixo, 1);
        check("post_wrap_saida", d0_saida, 0);
        drive(0, 1, 0, 1, 0, 8'd0, 0);
        tick();
        check("down_wrap_saida", d0_saida, 255);
        check("down_wrap_est", d0_est, 1);
        drive(0, 0, 0, 0, 0, 8'd0, 1);
        tick();
        check("limpar_fixo", d0_fixo, 0);

        // Crossing coinciding with limpar: set wins
        drive(0, 1, 1, 0, 0, 8'd0, 1);
        tick();
        check("coinc_saida", d0_saida, 0);
        check("coinc_fixo", d0_fixo, 1);

        // Restricted range 10..20 step 3: load 19 in both wrap and saturate units
        drive(0, 0, 0, 0, 1, 8'd19, 0);
        tick();
        check("ld19_wrap", d1_saida, 19);
        check("ld19_sat", d2_saida, 19);
        drive(0, 1, 1, 0, 0, 8'd0, 0);
        tick();
        check("wrap_up_saida", d1_saida, 11);
        check("wrap_up_est", d1_est, 1);
        check("sat_up1_saida", d2_saida, 20);
        check("sat_up1_est", d2_est, 1);
        check("sat_up1_em_max", d2_max, 1);
        tick();
        check("sat_up2_saida", d2_saida, 20);
        check("sat_up2_est", d2_est, 1);
        check("wrap_up2_saida", d1_saida, 14);
        check("wrap_up2_est", d1_est, 0);
        drive(0, 1, 0, 1, 0, 8'd0, 0);
        tick();
        check("wrap_dn1_saida", d1_saida, 11);
        check("wrap_dn1_est", d1_est, 0);
        check("sat_dn1_saida", d2_saida, 17);
        tick();
        check("wrap_dn2_saida", d1_saida, 19);
        check("wrap_dn2_est", d1_est, 1);
        check("sat_dn2_saida", d2_saida, 14);
        check("sat_dn2_est", d2_est, 0);

        // Load clamping at both bounds
        drive(0, 0, 0, 0, 1, 8'd5, 0);
        tick();
        check("ld5_sat", d2_saida, 10);
        check("ld5_sat_em_min", d2_min, 1);
        check("ld5_wrap", d1_saida, 10);
        check("ld5_def", d0_saida, 5);
        drive(0, 0, 0, 0, 1, 8'd30, 0);
        tick();
        check("ld30_wrap", d1_saida, 20);
        check("ld30_wrap_em_max", d1_max, 1);
        drive(0, 0, 0, 0, 1, 8'd5, 0);
        tick();

        // Hold cases: both requests, then enable low
        for (int i = 0; i < 4; i++) begin
            if (i < 2) drive(0, 1, 1, 1, 0, 8'd0, 0);
            else       drive(0, 0, 1, 0, 0, 8'd0, 0);
            tick();
            check($sformatf("hold_%0d", i), d0_saida, 5);
            check($sformatf("hold_est_%0d", i), d0_est, 0);
        end

        // Load beats counting
        drive(0, 1, 1, 0, 1, 8'd200, 0);
        tick();
        check("ld_vs_up", d0_saida, 200);

        // Reset beats load, clears the sticky flag
        check("pre_rst_fixo", d0_fixo, 1);
        drive(1, 1, 1, 0, 1, 8'd50, 0);
        tick();
        check("rst_vs_ld", d0_saida, 106);
        check("rst_vs_ld_fixo", d0_fixo, 0);
        drive(0, 1, 1, 0, 0, 8'd0, 0);
        tick();
        check("resume_after_rst", d0_saida, 107);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
